jtag_dr_sync: RTL and testbench
===============================

JTAG_DR_SYNC -- requirements
Module: jtag_dr_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops per TAP input (legal values 2..4).
REQ-002 SHALL have parameter DR_LEN, default 11, giving the data-register length; only 11 is supported.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  system clock, all logic on its rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 jtag_tck  in  1  TAP scan clock, sampled asynchronously as data.
REQ-006 jtag_tdi  in  1  TAP serial data in.
REQ-007 jtag_capture, jtag_shift, jtag_update, jtag_reset  in  1 each  TAP state strobes, already gated by USER select (update already delayed one tck).
REQ-008 jtag_tdo  out  1  serial data out to the TAP.
REQ-009 reg_q  in  8  host readback data, captured into the DR.
REQ-010 reg_addr_q  in  3  host readback address, captured into the DR.
REQ-011 reg_d  out  8  last accepted write data.
REQ-012 reg_addr_d  out  3  last accepted write address.
REQ-013 reg_update  out  1  one-clk_i pulse: a new reg_d/reg_addr_d was accepted.
REQ-014 reg_len_err  out  1  one-clk_i pulse: update rejected because of a bad shift length.

Function
REQ-015 Synchronization: every TAP input SHALL pass through a SYNC_STAGES flop chain; all other logic uses only the synchronized copies (tck_s, tdi_s, cap_s, sh_s, upd_s, jrst_s).
REQ-016 Edge detection: tck_rise SHALL equal tck_s & ~tck_s_d, where tck_s_d is tck_s delayed one clk_i.
REQ-017 Edge detection: upd_rise SHALL equal upd_s & ~upd_s_d.
REQ-018 Clock ratio: the block SHALL operate correctly for f(clk_i) >= 8 x f(jtag_tck); behaviour below this ratio is undefined.
REQ-019 Shift register: shreg[10:0] is defined as {data[7:0], addr[2:0]}.
REQ-020 Actions on tck_rise, in priority order jrst_s > cap_s > sh_s:
- jrst_s: shreg <= 0, cnt <= 0.
- cap_s: shreg <= {reg_q, reg_addr_q}, cnt <= 0.
- sh_s: shreg <= {tdi_s, shreg[10:1]}, cnt <= cnt+1, saturating at 15.
REQ-021 Shift order: bit shreg[0] leaves first, so the LSB of the address goes out first.
REQ-022 jtag_tdo SHALL be a registered copy of shreg[0] and SHALL update one clk_i after shreg changes.
REQ-023 FSM states SHALL be IDLE, SHIFTING and DONE.
- IDLE -> SHIFTING on the capture action.
- SHIFTING -> DONE on upd_rise.
- DONE -> IDLE on the next clk_i.
- Any state -> IDLE on jrst_s.
REQ-024 In DONE with cnt == 11: reg_d <= shreg[10:3], reg_addr_d <= shreg[2:0], and reg_update pulses for exactly 1 clk_i.
REQ-025 In DONE with cnt != 11: reg_d and reg_addr_d SHALL hold, reg_len_err pulses for 1 clk_i, and reg_update stays 0.
REQ-026 upd_rise while in IDLE (no capture since the last update) SHALL be ignored, with no pulse on either output.
REQ-027 If upd_rise and jrst_s are asserted together, jrst_s SHALL win and produce no pulse.
REQ-028 If a capture occurs while in SHIFTING, the block SHALL restart the shift: reload shreg, set cnt <= 0 and stay in SHIFTING.
REQ-029 reg_update and reg_len_err SHALL never be high in the same cycle, and never for two consecutive cycles.
REQ-030 Update latency: from the jtag_update rising edge to the reg_update pulse SHALL be SYNC_STAGES+2 clk_i cycles.

Reset
REQ-031 On rst_i high at a clk_i edge, the following SHALL clear to 0: synchronizer chains, tck_s_d, upd_s_d, shreg, cnt, jtag_tdo, reg_d, reg_addr_d, reg_update, reg_len_err; the FSM SHALL go to IDLE.
REQ-032 rst_i SHALL override every other event in that cycle.
REQ-033 rst_i asserted mid-shift SHALL abort the transfer; a later update without a fresh capture SHALL produce no pulse.
REQ-034 jtag_reset SHALL NOT clear reg_d or reg_addr_d; only rst_i clears them.

Verification
REQ-035 Write: clk_i 100 MHz, tck 5 MHz; capture, then shift in 11 bits of 0x5A3 (LSB first), then update -> reg_d=0xB4, reg_addr_d=0x3, one reg_update pulse 4 clk_i after the update edge.
REQ-036 Readback: reg_q=0xC3, reg_addr_q=0x5; capture, then 11 shifts -> jtag_tdo sequence (LSB first) = 1,0,1,1,1,0,0,0,0,1,1.
REQ-037 Short shift: capture, then 10 shifts, then update -> one reg_len_err pulse, no reg_update, reg_d unchanged.
REQ-038 Long shift: capture, then 20 shifts -> cnt saturates at 15; update -> reg_len_err pulse.
REQ-039 Reset mid-shift: rst_i after 5 shifts, then 6 more shifts, then update -> no pulses, all outputs 0.
REQ-040 jtag_reset mid-shift: jtag_reset asserted, then update -> no pulse, reg_d holds its prior value.

Source files
------------

// File: rtl/jtag_dr_sync.sv
// USER data-register bridge: oversamples the TAP signals on clk_i and turns a
// captured/shifted/updated 11-bit DR {data, addr} into host write pulses.
module jtag_dr_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DR_LEN      = 11
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       jtag_tck,
    input  logic       jtag_tdi,
    input  logic       jtag_capture,
    input  logic       jtag_shift,
    input  logic       jtag_update,
    input  logic       jtag_reset,
    output logic       jtag_tdo,
    input  logic [7:0] reg_q,
    input  logic [2:0] reg_addr_q,
    output logic [7:0] reg_d,
    output logic [2:0] reg_addr_d,
    output logic       reg_update,
    output logic       reg_len_err
);

    localparam logic [3:0] LenOk  = 4'(DR_LEN);
    localparam logic [3:0] CntMax = 4'd15;

    typedef enum logic [1:0] {StIdle, StShifting, StDone} state_e;

    // Bit order in each stage: {jrst, upd, sh, cap, tdi, tck}
    logic [5:0] sync_q [SYNC_STAGES];
    logic       tck_s, tdi_s, cap_s, sh_s, upd_s, jrst_s;
    logic       tck_s_d, upd_s_d;
    logic       tck_rise, upd_rise, capture_act;
    logic [10:0] shreg;
    logic [3:0]  cnt;
    state_e      state;

    assign tck_s  = sync_q[SYNC_STAGES-1][0];
    assign tdi_s  = sync_q[SYNC_STAGES-1][1];
    assign cap_s  = sync_q[SYNC_STAGES-1][2];
    assign sh_s   = sync_q[SYNC_STAGES-1][3];
    assign upd_s  = sync_q[SYNC_STAGES-1][4];
    assign jrst_s = sync_q[SYNC_STAGES-1][5];

    assign tck_rise    = tck_s & ~tck_s_d;
    assign upd_rise    = upd_s & ~upd_s_d;
    assign capture_act = tck_rise & ~jrst_s & cap_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            tck_s_d <= 1'b0;
            upd_s_d <= 1'b0;
        end else begin
            sync_q[0] <= {jtag_reset, jtag_update, jtag_shift, jtag_capture, jtag_tdi, jtag_tck};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            tck_s_d <= tck_s;
            upd_s_d <= upd_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg    <= '0;
            cnt      <= '0;
            jtag_tdo <= 1'b0;
        end else begin
            jtag_tdo <= shreg[0];
            if (tck_rise) begin
                if (jrst_s) begin
                    shreg <= '0;
                    cnt   <= '0;
                end else if (cap_s) begin
                    shreg <= {reg_q, reg_addr_q};
                    cnt   <= '0;
                end else if (sh_s) begin
                    shreg <= {tdi_s, shreg[10:1]};
                    if (cnt != CntMax) cnt <= cnt + 4'd1;
                end
            end
        end
    end

    // jtag_reset forces IDLE at any level so a coincident update is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= StIdle;
            reg_d       <= '0;
            reg_addr_d  <= '0;
            reg_update  <= 1'b0;
            reg_len_err <= 1'b0;
        end else begin
            reg_update  <= 1'b0;
            reg_len_err <= 1'b0;
            if (jrst_s) begin
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (capture_act) state <= StShifting;
                    end
                    StShifting: begin
                        if (!capture_act && upd_rise) state <= StDone;
                    end
                    StDone: begin
                        state <= StIdle;
                        if (cnt == LenOk) begin
                            reg_d      <= shreg[10:3];
                            reg_addr_d <= shreg[2:0];
                            reg_update <= 1'b1;
                        end else begin
                            reg_len_err <= 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_dr_sync.sv
// Directed bench for jtag_dr_sync: table of write transfers plus hand-written
// readback, restart, jtag_reset and rst_i corner sequences.
module tb_jtag_dr_sync;

    logic       clk = 1'b0;
    logic       rst, tck, tdi, cap, sh, upd, jrst;
    logic       tdo;
    logic [7:0] reg_q, reg_d;
    logic [2:0] reg_addr_q, reg_addr_d;
    logic       reg_update, reg_len_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtag_dr_sync #(.SYNC_STAGES(2), .DR_LEN(11)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .jtag_tck    (tck),
        .jtag_tdi    (tdi),
        .jtag_capture(cap),
        .jtag_shift  (sh),
        .jtag_update (upd),
        .jtag_reset  (jrst),
        .jtag_tdo    (tdo),
        .reg_q       (reg_q),
        .reg_addr_q  (reg_addr_q),
        .reg_d       (reg_d),
        .reg_addr_d  (reg_addr_d),
        .reg_update  (reg_update),
        .reg_len_err (reg_len_err)
    );

    typedef struct {
        logic [19:0] bits;
        int          n;
        int          lat;
        int          n_upd;
        int          n_err;
        logic [7:0]  exp_d;
        logic [2:0]  exp_a;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 5 MHz tck against 100 MHz clk_i
    task automatic tck_pulse();
        tck = 1'b1;
        wait_clks(10);
        tck = 1'b0;
        wait_clks(10);
    endtask

    task automatic do_capture();
        cap = 1'b1;
        tck_pulse();
        cap = 1'b0;
    endtask

    task automatic shift_bits(input logic [19:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            sh  = 1'b1;
            tdi = v[i];
            tck_pulse();
        end
        sh  = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic do_update(output int lat, output int n_upd, output int n_err, output int n_both);
        lat = 0; n_upd = 0; n_err = 0; n_both = 0;
        upd = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if ((reg_update || reg_len_err) && lat == 0) lat = i;
            if (reg_update) n_upd++;
            if (reg_len_err) n_err++;
            if (reg_update && reg_len_err) n_both++;
            if (i == 15) upd = 1'b0;
        end
    endtask

    int lat, n_upd, n_err, n_both;
    int exp_tdo[11] = '{1, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1};

    initial begin
        vecs[0] = '{bits: 20'h005A3, n: 11, lat: 4, n_upd: 1, n_err: 0, exp_d: 8'hB4, exp_a: 3'h3};
        vecs[1] = '{bits: 20'h00000, n: 11, lat: 4, n_upd: 1, n_err: 0, exp_d: 8'h00, exp_a: 3'h0};
        vecs[2] = '{bits: 20'h000F2, n: 11, lat: 4, n_upd: 1, n_err: 0, exp_d: 8'h1E, exp_a: 3'h2};
        vecs[3] = '{bits: 20'h007FF, n: 10, lat: 4, n_upd: 0, n_err: 1, exp_d: 8'h1E, exp_a: 3'h2};
        vecs[4] = '{bits: 20'h00123, n: 20, lat: 4, n_upd: 0, n_err: 1, exp_d: 8'h1E, exp_a: 3'h2};
        vecs[5] = '{bits: 20'h007FF, n: 11, lat: 4, n_upd: 1, n_err: 0, exp_d: 8'hFF, exp_a: 3'h7};

        rst = 1'b1; tck = 1'b0; tdi = 1'b0; cap = 1'b0; sh = 1'b0; upd = 1'b0; jrst = 1'b0;
        reg_q = 8'h00; reg_addr_q = 3'h0;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2);
        check("reset_tdo", 32'(tdo), 0);
        check("reset_reg_d", 32'(reg_d), 0);
        check("reset_reg_addr_d", 32'(reg_addr_d), 0);
        check("reset_reg_update", 32'(reg_update), 0);
        check("reset_reg_len_err", 32'(reg_len_err), 0);

        // Readback: tdo presents the DR LSB first
        reg_q = 8'hC3; reg_addr_q = 3'h5;
        do_capture();
        check("readback_bit0", 32'(tdo), 32'(exp_tdo[0]));
        for (int k = 1; k < 11; k++) begin
            shift_bits(20'h0, 1);
            check($sformatf("readback_bit%0d", k), 32'(tdo), 32'(exp_tdo[k]));
        end

        reg_q = 8'h00; reg_addr_q = 3'h0;
        for (int v = 0; v < 6; v++) begin
            do_capture();
            shift_bits(vecs[v].bits, vecs[v].n);
            do_update(lat, n_upd, n_err, n_both);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            check($sformatf("vec%0d_update_cycles", v), 32'(n_upd), 32'(vecs[v].n_upd));
            check($sformatf("vec%0d_len_err_cycles", v), 32'(n_err), 32'(vecs[v].n_err));
            check($sformatf("vec%0d_reg_d", v), 32'(reg_d), 32'(vecs[v].exp_d));
            check($sformatf("vec%0d_reg_addr_d", v), 32'(reg_addr_d), 32'(vecs[v].exp_a));
        end

        // Update with no capture since the last update is ignored
        do_update(lat, n_upd, n_err, n_both);
        check("nocap_pulses", 32'(n_upd + n_err), 0);
        check("nocap_reg_d", 32'(reg_d), 32'h FF);

        // Capture while shifting restarts the transfer
        do_capture();
        shift_bits(20'h0001F, 5);
        do_capture();
        shift_bits(20'h000F2, 11);
        do_update(lat, n_upd, n_err, n_both);
        check("restart_update_cycles", 32'(n_upd), 1);
        check("restart_len_err_cycles", 32'(n_err), 0);
        check("restart_reg_d", 32'(reg_d), 32'h1E);
        check("restart_reg_addr_d", 32'(reg_addr_d), 32'h2);

        // jtag_reset mid-shift aborts; reg_d holds
        do_capture();
        shift_bits(20'h0001F, 5);
        jrst = 1'b1;
        tck_pulse();
        jrst = 1'b0;
        do_update(lat, n_upd, n_err, n_both);
        check("jrst_pulses", 32'(n_upd + n_err), 0);
        check("jrst_reg_d", 32'(reg_d), 32'h1E);
        check("jrst_reg_addr_d", 32'(reg_addr_d), 32'h2);

        // jtag_reset coincident with update wins
        do_capture();
        shift_bits(20'h005A3, 11);
        jrst = 1'b1;
        wait_clks(5);
        do_update(lat, n_upd, n_err, n_both);
        jrst = 1'b0;
        check("jrst_upd_pulses", 32'(n_upd + n_err), 0);
        check("jrst_upd_reg_d", 32'(reg_d), 32'h1E);
        wait_clks(5);

        // rst_i mid-shift clears everything; later update needs a fresh capture
        do_capture();
        shift_bits(20'h0001F, 5);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        shift_bits(20'h0003F, 6);
        do_update(lat, n_upd, n_err, n_both);
        check("rst_pulses", 32'(n_upd + n_err), 0);
        check("rst_reg_d", 32'(reg_d), 0);
        check("rst_reg_addr_d", 32'(reg_addr_d), 0);
        check("rst_tdo", 32'(tdo), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
